ps2_hex_entry: RTL

Input-side counterpart of the seven-segment display path. Receives PS/2 keyboard frames and decodes hex-key make codes, then accumulates the digits into a DISPLAY_WIDTH-bit value. That value drives the display's display_i, so typed digits appear on the segments. Sits at the FPGA top level between the keyboard pins and the display driver.

---
 rtl/ps2_pkg.sv | 65 ++++++
 rtl/ps2_frame_rx.sv | 109 ++++++++++
 rtl/ps2_hex_entry.sv | 91 +++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_pkg                                                              |
// | PS/2 scan-code constants, receiver states and hex-key decode helper. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  // Returns {hit, nibble}; hit is 0 for any non-hex code.
  function automatic logic [4:0] scan_to_hex(input logic [7:0] code);
    logic [4:0] r;
    r = 5'b0_0000;
    case (code)
      SC_0: r = 5'h10;
      SC_1: r = 5'h11;
      SC_2: r = 5'h12;
      SC_3: r = 5'h13;
      SC_4: r = 5'h14;
      SC_5: r = 5'h15;
      SC_6: r = 5'h16;
      SC_7: r = 5'h17;
      SC_8: r = 5'h18;
      SC_9: r = 5'h19;
      SC_A: r = 5'h1A;
      SC_B: r = 5'h1B;
      SC_C: r = 5'h1C;
      SC_D: r = 5'h1D;
      SC_E: r = 5'h1E;
      SC_F: r = 5'h1F;
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_frame_rx                                                         |
// | PS/2 frame receiver: pin synchronisers, strobe, framing FSM, timeout.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       err_o
);

  localparam int               TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]    C_TIMER_END = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  rx_state_e     r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_byte;
  logic          r_byte_valid;
  logic          r_err;

  logic w_strobe;
  logic w_data;

  assign w_strobe = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_data   = r_data_sync[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_clk_sync   <= 3'b111;
      r_data_sync  <= 2'b11;
      r_state      <= IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_parity     <= 1'b0;
      r_timer      <= '0;
      r_byte       <= 8'h00;
      r_byte_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_clk_sync   <= {r_clk_sync[1:0], ps2_clk_i};
      r_data_sync  <= {r_data_sync[0], ps2_data_i};
      r_byte_valid <= 1'b0;
      r_err        <= 1'b0;
      if (w_strobe) begin
        r_timer <= '0;
        case (r_state)
          IDLE: begin
            if (!w_data) begin
              r_state   <= DATA;
              r_bit_cnt <= 3'd0;
            end else begin
              r_err <= 1'b1;
            end
          end
          DATA: begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_parity <= w_data;
            r_state  <= STOP;
          end
          STOP: begin
            // Odd parity: data plus parity bit must hold an odd count of ones.
            if (w_data && (^{r_shift, r_parity})) begin
              r_byte       <= r_shift;
              r_byte_valid <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_state != IDLE) begin
        if (r_timer == C_TIMER_END) begin
          r_err   <= 1'b1;
          r_state <= IDLE;
          r_timer <= '0;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end else begin
        r_timer <= '0;
      end
    end
  end

  assign byte_o       = r_byte;
  assign byte_valid_o = r_byte_valid;
  assign err_o        = r_err;

endmodule
`default_nettype wire

// File: rtl/ps2_hex_entry.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_hex_entry                                                        |
// | Decodes PS/2 hex keys and accumulates them into a display value.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_hex_entry
  import ps2_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ps2_clk_i,
  input  logic                     ps2_data_i,
  output logic [DISPLAY_WIDTH-1:0] value_o,
  output logic                     digit_valid_o,
  output logic [3:0]               digit_o,
  output logic                     frame_err_o
);

  generate
    if ((DISPLAY_WIDTH % 4) != 0 || DISPLAY_WIDTH < 8) begin : g_width_check
      $error("ps2_hex_entry: DISPLAY_WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_err;
  logic [4:0] w_hex;

  logic [DISPLAY_WIDTH-1:0] r_value;
  logic [3:0]               r_digit;
  logic                     r_digit_valid;
  logic                     r_break;
  logic                     r_ext;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_data_i   (ps2_data_i),
    .byte_o       (w_byte),
    .byte_valid_o (w_byte_valid),
    .err_o        (w_err)
  );

  assign w_hex = scan_to_hex(w_byte);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_value       <= '0;
      r_digit       <= 4'h0;
      r_digit_valid <= 1'b0;
      r_break       <= 1'b0;
      r_ext         <= 1'b0;
    end else begin
      r_digit_valid <= 1'b0;
      if (w_byte_valid) begin
        if (w_byte == SC_BREAK) begin
          r_break <= 1'b1;
        end else if (w_byte == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (r_break || r_ext) begin
          // Byte following a prefix belongs to a release or extended key.
          r_break <= 1'b0;
          r_ext   <= 1'b0;
        end else if (w_hex[4]) begin
          r_value       <= {r_value[DISPLAY_WIDTH-5:0], w_hex[3:0]};
          r_digit       <= w_hex[3:0];
          r_digit_valid <= 1'b1;
        end else if (w_byte == SC_BKSP) begin
          r_value <= r_value >> 4;
        end else if (w_byte == SC_ESC) begin
          r_value <= '0;
        end
      end
    end
  end

  assign value_o       = r_value;
  assign digit_o       = r_digit;
  assign digit_valid_o = r_digit_valid;
  assign frame_err_o   = w_err;

endmodule
`default_nettype wire
